// File: rtl/pipe_stage_skid.sv
// Single pipeline stage with registered output and an optional skid entry.
// DEPTH=2 keeps in_ready flop-driven; DEPTH=1 is a plain register stage.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  // Encoding doubles as the live-entry count.
  typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} state_t;

  localparam bit HAS_SKID = (DEPTH == 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  generate
    if (DEPTH == 2) begin : g_skid
      assign in_ready = (state != SKID);
    end else if (DEPTH == 1) begin : g_single
      assign in_ready = !out_valid || out_ready;
    end else begin : g_bad_depth
      $error("pipe_stage_skid: DEPTH must be 1 or 2");
    end
  endgenerate

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

  // Non-live entries are forced to zero so a bubble reads as a squashed word.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            main_q <= in_data;
            state  <= FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (in_valid) begin
              main_q <= in_data;
            end else begin
              main_q <= '0;
              state  <= EMPTY;
            end
          end else if (in_valid && HAS_SKID) begin
            skid_q <= in_data;
            state  <= SKID;
          end
        end
        SKID: begin
          if (out_ready) begin
            main_q <= skid_q;
            skid_q <= '0;
            state  <= FULL;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= '0;
          skid_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_pipe_stage_skid;

  logic        clk;
  logic        reset, flush, in_valid, out_ready, stall_clr;
  logic [15:0] in_data;

  logic        rdy2, vld2, rdy1, vld1, rdys, vlds;
  logic [15:0] dat2, dat1, dats;
  logic [1:0]  occ2, occ1, occs;
  logic [15:0] cnt2_o, cnt1_o;
  logic [1:0]  cnts_o;

  pipe_stage_skid #(.DATA_W(16), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy2), .out_valid(vld2), .out_data(dat2), .out_ready(out_ready),
    .occupancy(occ2), .stall_cnt(cnt2_o), .stall_clr(stall_clr));

  pipe_stage_skid #(.DATA_W(16), .DEPTH(1), .CNT_W(16)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .out_valid(vld1), .out_data(dat1), .out_ready(out_ready),
    .occupancy(occ1), .stall_cnt(cnt1_o), .stall_clr(stall_clr));

  pipe_stage_skid #(.DATA_W(16), .DEPTH(2), .CNT_W(2)) u_ds (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdys), .out_valid(vlds), .out_data(dats), .out_ready(out_ready),
    .occupancy(occs), .stall_cnt(cnts_o), .stall_clr(stall_clr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents per depth plus stall counters.
  logic [15:0] q2[$];
  logic [15:0] q1[$];
  int          m_cnt2, m_cnt1, m_cnts;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] head(input logic [15:0] q[$]);
    return (q.size() > 0) ? q[0] : 16'h0;
  endfunction

  task automatic check_model();
    chk("d2.valid", 64'(vld2), 64'(q2.size() > 0));
    chk("d2.data",  64'(dat2), 64'(head(q2)));
    chk("d2.occ",   64'(occ2), 64'(q2.size()));
    chk("d2.ready", 64'(rdy2), 64'(q2.size() < 2));
    chk("d2.cnt",   64'(cnt2_o), 64'(m_cnt2));
    chk("ds.data",  64'(dats), 64'(head(q2)));
    chk("ds.occ",   64'(occs), 64'(q2.size()));
    chk("ds.cnt",   64'(cnts_o), 64'(m_cnts));
    chk("d1.valid", 64'(vld1), 64'(q1.size() > 0));
    chk("d1.data",  64'(dat1), 64'(head(q1)));
    chk("d1.occ",   64'(occ1), 64'(q1.size()));
    chk("d1.ready", 64'(rdy1), 64'(q1.size() == 0 || out_ready));
    chk("d1.cnt",   64'(cnt1_o), 64'(m_cnt1));
  endtask

  task automatic model_step();
    bit a2, c2, s2, a1, c1, s1;
    a2 = in_valid && q2.size() < 2;
    c2 = q2.size() > 0 && out_ready;
    s2 = q2.size() > 0 && !out_ready;
    a1 = in_valid && (q1.size() == 0 || out_ready);
    c1 = q1.size() > 0 && out_ready;
    s1 = q1.size() > 0 && !out_ready;
    if (!reset) begin
      q2.delete(); q1.delete();
      m_cnt2 = 0; m_cnt1 = 0; m_cnts = 0;
    end else begin
      if (flush) begin
        q2.delete(); q1.delete();
      end else begin
        if (c2) void'(q2.pop_front());
        if (a2) q2.push_back(in_data);
        if (c1) void'(q1.pop_front());
        if (a1) q1.push_back(in_data);
      end
      if (stall_clr) begin
        m_cnt2 = 0; m_cnt1 = 0; m_cnts = 0;
      end else begin
        if (s2 && m_cnt2 < 65535) m_cnt2++;
        if (s2 && m_cnts < 3) m_cnts++;
        if (s1 && m_cnt1 < 65535) m_cnt1++;
      end
    end
  endtask

  // Inputs are already applied; check pre-edge outputs, clock, advance model.
  task automatic tick();
    #1;
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [15:0] d,
                       input logic ordy, input logic clr);
    reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy; stall_clr = clr;
  endtask

  typedef struct {
    logic        r, f, iv;
    logic [15:0] d;
    logic        ordy, clr;
    logic        ev;
    logic [15:0] ed;
    logic [1:0]  eocc;
    logic        erdy;
    logic [15:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [15:0] d,
                              input logic ordy, input logic clr, input logic ev,
                              input logic [15:0] ed, input logic [1:0] eocc,
                              input logic erdy, input logic [15:0] ecnt);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eocc = eocc; v.erdy = erdy; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Expected DEPTH=2 outputs after each vector's clock edge.
    tbl.push_back(mk(1,0,1,16'h11,1,0, 1,16'h11,1,1,0));
    tbl.push_back(mk(1,0,1,16'h22,1,0, 1,16'h22,1,1,0));
    tbl.push_back(mk(1,0,1,16'h33,1,0, 1,16'h33,1,1,0));
    tbl.push_back(mk(1,0,0,16'h00,1,0, 0,16'h00,0,1,0));
    tbl.push_back(mk(1,0,1,16'hA1,0,0, 1,16'hA1,1,1,0));
    tbl.push_back(mk(1,0,1,16'hA2,0,0, 1,16'hA1,2,0,1));
    tbl.push_back(mk(1,0,1,16'hA3,0,0, 1,16'hA1,2,0,2));
    tbl.push_back(mk(1,0,0,16'h00,1,0, 1,16'hA2,1,1,2));
    tbl.push_back(mk(1,0,0,16'h00,1,0, 0,16'h00,0,1,2));
    tbl.push_back(mk(1,0,1,16'hB1,0,0, 1,16'hB1,1,1,2));
    tbl.push_back(mk(1,0,1,16'hB2,0,0, 1,16'hB1,2,0,3));
    tbl.push_back(mk(1,1,1,16'hFF,0,0, 0,16'h00,0,1,4));
    tbl.push_back(mk(1,0,0,16'h00,1,0, 0,16'h00,0,1,4));
    tbl.push_back(mk(1,0,0,16'h00,1,1, 0,16'h00,0,1,0));
    tbl.push_back(mk(1,0,1,16'hC1,0,0, 1,16'hC1,1,1,0));
    tbl.push_back(mk(1,0,0,16'h00,0,0, 1,16'hC1,1,1,1));
    tbl.push_back(mk(1,0,0,16'h00,0,0, 1,16'hC1,1,1,2));
    tbl.push_back(mk(1,0,0,16'h00,0,1, 1,16'hC1,1,1,0));
    tbl.push_back(mk(1,0,0,16'h00,0,0, 1,16'hC1,1,1,1));
    tbl.push_back(mk(1,0,0,16'h00,0,0, 1,16'hC1,1,1,2));
    tbl.push_back(mk(1,0,1,16'hC2,0,0, 1,16'hC1,2,0,3));
    tbl.push_back(mk(1,0,0,16'h00,0,0, 1,16'hC1,2,0,4));
    tbl.push_back(mk(1,0,0,16'h00,0,0, 1,16'hC1,2,0,5));
    tbl.push_back(mk(1,0,0,16'h00,0,0, 1,16'hC1,2,0,6));
    tbl.push_back(mk(1,0,0,16'h00,0,0, 1,16'hC1,2,0,7));
    tbl.push_back(mk(0,0,1,16'hEE,0,0, 0,16'h00,0,1,0));
    tbl.push_back(mk(1,0,1,16'hD1,0,0, 1,16'hD1,1,1,0));
    tbl.push_back(mk(1,0,0,16'h00,1,0, 0,16'h00,0,1,0));

    drive(0, 0, 1, 16'h5A, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst.valid", 64'(vld2), 64'd0);
    chk("rst.data",  64'(dat2), 64'd0);
    chk("rst.occ",   64'(occ2), 64'd0);
    chk("rst.cnt",   64'(cnt2_o), 64'd0);
    chk("rst.d1rdy", 64'(rdy1), 64'd1);
    drive(1, 0, 0, 16'h0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d.valid", i), 64'(vld2),   64'(tbl[i].ev));
      chk($sformatf("vec%0d.data", i),  64'(dat2),   64'(tbl[i].ed));
      chk($sformatf("vec%0d.occ", i),   64'(occ2),   64'(tbl[i].eocc));
      chk($sformatf("vec%0d.ready", i), 64'(rdy2),   64'(tbl[i].erdy));
      chk($sformatf("vec%0d.cnt", i),   64'(cnt2_o), 64'(tbl[i].ecnt));
      if (i == 24) chk("sat.cnt", 64'(cnts_o), 64'd3);
    end

    // DEPTH=1 replace-in-place: live entry consumed and reloaded the same cycle.
    drive(1, 0, 1, 16'hE1, 1, 0);
    tick();
    chk("d1.load", 64'(dat1), 64'hE1);
    drive(1, 0, 1, 16'hE2, 1, 0);
    #1;
    chk("d1.rdy_full", 64'(rdy1), 64'd1);
    tick();
    chk("d1.replace.valid", 64'(vld1), 64'd1);
    chk("d1.replace.data",  64'(dat1), 64'hE2);

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(63) != 0), ($urandom_range(15) == 0), $urandom_range(1) == 1,
            16'($urandom), ($urandom_range(3) != 0) ^ (n[8] == 1'b1), ($urandom_range(15) == 0));
      tick();
    end
    drive(1, 0, 0, 16'h0, 1, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
